reg_file_wb: RTL
================

Name: reg_file_wb

Overview:
- RV32I integer register file, the receiving end of the writeback stage: takes the selected writeback data, destination and write enable, and commits them to architectural state.
- Provides two registered read ports to decode with same-cycle write-to-read bypass. x0 is hardwired to zero.
- Keeps a per-register pending-write scoreboard and raises a stall when decode reads a register whose producer has not yet written back.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; the file holds 2**ADDR_W registers
SP_INIT, 32'h0000_0000, reset value of x2 (sp); all other registers reset to 0

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
WE_IN  in  1  writeback enable (writeback control bit)
WADDR_IN  in  ADDR_W  writeback destination rd
WDATA_IN  in  DATA_W  writeback data (memory or execute result, already selected)
RD_EN_IN  in  1  decode read strobe; read outputs update only when high
RADDR1_IN  in  ADDR_W  rs1 index
RADDR2_IN  in  ADDR_W  rs2 index
ISSUE_IN  in  1  decode issues an instruction that will write rd
ISSUE_RD_IN  in  ADDR_W  rd of the issued instruction
RDATA1_OUT  out  DATA_W  registered rs1 value
RDATA2_OUT  out  DATA_W  registered rs2 value
STALL_OUT  out  1  combinational; a source of the current read is pending

Behaviour:
- Reset (RST_N low, asynchronous): all registers 0 except x2 = SP_INIT; RDATA1_OUT = RDATA2_OUT = 0; all busy bits 0; STALL_OUT = 0. Reset mid-operation discards pending writes and busy bits immediately.
- Write: on a rising edge with WE_IN = 1 and WADDR_IN != 0, reg[WADDR_IN] <= WDATA_IN. Writes to x0 are dropped silently.
- Read: one-cycle latency. On a rising edge with RD_EN_IN = 1 and STALL_OUT = 0, each RDATAn_OUT is loaded with:
  - 0 if RADDRn_IN = 0;
  - otherwise WDATA_IN if WE_IN = 1 and WADDR_IN = RADDRn_IN (bypass);
  - otherwise reg[RADDRn_IN].
- When RD_EN_IN = 0 or STALL_OUT = 1, both RDATAn_OUT hold their previous values.
- Both ports may address the same register; both return the same value.
- Scoreboard: one busy bit per register. busy[0] is always 0.
  - Set on a rising edge when ISSUE_IN = 1, ISSUE_RD_IN != 0 and STALL_OUT = 0. An issue attempted while stalled is ignored.
  - Cleared on a rising edge when WE_IN = 1 and WADDR_IN matches.
  - Issue and writeback to the same register in the same cycle: set wins, because the new producer is outstanding.
  - Issue to a register that is already busy keeps the bit set. There is no counting; the pipeline guarantees in-order writeback.
- STALL_OUT = RD_EN_IN & (p1 | p2), where pn = busy[RADDRn_IN] & (RADDRn_IN != 0) & ~(WE_IN & WADDR_IN == RADDRn_IN). A writeback in the same cycle satisfies the hazard through the bypass.
- There are no X outputs after reset. Out-of-range indices cannot occur, since ADDR_W fully covers the file.

Test Plan:
1. Reset: assert RST_N = 0 mid-run, then read x1, x2, x31 → RDATA = 0, 32'h0000_0000 (SP_INIT), 0; STALL_OUT = 0.
2. Write and read: WE_IN = 1, WADDR_IN = 5, WDATA_IN = 32'hDEAD_BEEF; next cycle RD_EN_IN = 1, RADDR1_IN = 5 → RDATA1_OUT = 32'hDEAD_BEEF one edge later. Write 32'h1234_5678 to x0, then read x0 on both ports → 0 and 0.
3. Bypass: in the same cycle, WE_IN = 1, WADDR_IN = 7, WDATA_IN = 32'hA5A5_A5A5 and RD_EN_IN = 1, RADDR1_IN = RADDR2_IN = 7 → after one edge, both RDATA = 32'hA5A5_A5A5.
4. Scoreboard stall:
   - Issue rd = 9. Next cycle read rs1 = 9 with no writeback → STALL_OUT = 1 and RDATA holds.
   - Writeback x9 = 32'h0000_0042 in the stall cycle → STALL_OUT drops to 0 that cycle and RDATA1_OUT = 32'h42 after the edge.
   - busy[9] is cleared.
5. Simultaneous set and clear: issue rd = 3 and writeback x3 = 32'h1 in the same cycle → next cycle reading x3 gives STALL_OUT = 1. Issue rd = 0 → reading x0 never stalls.
6. Issue while stalled: stall on x9 while ISSUE_IN = 1, ISSUE_RD_IN = 12 → busy[12] stays 0. After stall release, reading x12 gives STALL_OUT = 0.

Source files
------------

// File: rtl/reg_file_wb.sv
// RV32I integer register file at the writeback boundary: two registered read ports
// with write-to-read bypass, x0 hardwired to zero, and a pending-write scoreboard.
module reg_file_wb #(
    parameter int unsigned          DATA_W  = 32,
    parameter int unsigned          ADDR_W  = 5,
    parameter logic [DATA_W-1:0]    SP_INIT = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WE_IN,
    input  logic [ADDR_W-1:0] WADDR_IN,
    input  logic [DATA_W-1:0] WDATA_IN,
    input  logic              RD_EN_IN,
    input  logic [ADDR_W-1:0] RADDR1_IN,
    input  logic [ADDR_W-1:0] RADDR2_IN,
    input  logic              ISSUE_IN,
    input  logic [ADDR_W-1:0] ISSUE_RD_IN,
    output logic [DATA_W-1:0] RDATA1_OUT,
    output logic [DATA_W-1:0] RDATA2_OUT,
    output logic              STALL_OUT
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;

    logic              w_pend1;
    logic              w_pend2;
    logic              w_stall;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [NREG-1:0]   w_busy_nxt;

    // A writeback landing this cycle resolves the hazard through the bypass.
    always_comb begin
        w_pend1 = r_busy[RADDR1_IN] && (RADDR1_IN != '0)
                  && !(WE_IN && (WADDR_IN == RADDR1_IN));
        w_pend2 = r_busy[RADDR2_IN] && (RADDR2_IN != '0)
                  && !(WE_IN && (WADDR_IN == RADDR2_IN));
        w_stall = RD_EN_IN && (w_pend1 || w_pend2);
    end

    always_comb begin
        if (RADDR1_IN == '0)
            w_rd1 = '0;
        else if (WE_IN && (WADDR_IN == RADDR1_IN))
            w_rd1 = WDATA_IN;
        else
            w_rd1 = r_regs[RADDR1_IN];

        if (RADDR2_IN == '0)
            w_rd2 = '0;
        else if (WE_IN && (WADDR_IN == RADDR2_IN))
            w_rd2 = WDATA_IN;
        else
            w_rd2 = r_regs[RADDR2_IN];
    end

    // Set is applied after clear so a new producer issued in the writeback cycle stays outstanding.
    always_comb begin
        w_busy_nxt = r_busy;
        if (WE_IN)
            w_busy_nxt[WADDR_IN] = 1'b0;
        if (ISSUE_IN && (ISSUE_RD_IN != '0) && !w_stall)
            w_busy_nxt[ISSUE_RD_IN] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_regs[i] <= (i == 2) ? SP_INIT : '0;
        end else if (WE_IN && (WADDR_IN != '0)) begin
            r_regs[WADDR_IN] <= WDATA_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else if (RD_EN_IN && !w_stall) begin
            r_rdata1 <= w_rd1;
            r_rdata2 <= w_rd2;
        end
    end

    assign RDATA1_OUT = r_rdata1;
    assign RDATA2_OUT = r_rdata2;
    assign STALL_OUT  = w_stall;

endmodule
